seg7_scan_display: RTL
======================

Name: seg7_scan_display

Overview:
- Downstream consumer of the parallel output port's 32-bit register value.
- Converts the value to 8 decimal digits with a sequential double-dabble engine.
- Time-multiplexes the digits onto an 8-digit common-anode 7-segment display.
- Optional leading-zero blanking; values that do not fit in 8 digits are flagged as overflow.

Parameters:
- SCAN_DIV, 50000: clk cycles each digit stays lit; 2..2^20.
- LZ_BLANK, 1: 1 = blank leading zeros; 0 = show all 8 digits.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- DataIn  input  32  unsigned binary value to display
- Anode  output  8  digit enables, active-low one-hot; bit0 = rightmost (least significant) digit
- Segments  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}
- Busy  output  1  high while a conversion is in progress
- Overflow  output  1  high when the last converted value was greater than 99_999_999

Behaviour:
- Reset (rst low, asynchronous) sets every register to 0 and the FSM to IDLE. Resulting outputs:
  - Busy = 0, Overflow = 0.
  - Digit index = 0, so Anode = 8'b11111110.
  - All display digits = 0; digit 0 is never blanked, so Segments = 7'b1000000.
  - Shadow register = 0.
- Conversion FSM states: IDLE, SHIFT, DONE.
  - IDLE: if DataIn != shadow on a clk edge: shadow <= DataIn, binary shift reg <= DataIn, 40-bit BCD reg <= 0, bit counter <= 0, Busy <= 1, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT, one bit per cycle:
    - Each BCD nibble >= 5 gets +3 (combinational).
    - Then {BCD, binary} shifts left by 1.
    - The counter increments; after the 32nd shift, go to DONE.
  - DONE, one cycle:
    - If BCD[39:32] != 0: Overflow <= 1, and all 8 display digits are set to the dash code.
    - Else: Overflow <= 0, and the display digits are loaded from BCD[31:0].
    - Busy <= 0; go to IDLE.
  - Busy is high for exactly 33 cycles. Display registers and Overflow change only on the edge that clears Busy.
  - DataIn changes during SHIFT/DONE are ignored. Back in IDLE, the mismatch with shadow is seen and a new conversion starts the next cycle. The last value always ends up displayed.
- Scan logic, independent of the FSM:
  - Prescaler counts 0..SCAN_DIV-1.
  - At terminal count it wraps to 0 and the digit index advances 0 -> 1 -> ... -> 7 -> 0.
  - Anode = ~(1 << index), registered. Segments is decoded from the display register of the current index and registered in the same cycle as Anode, so they never mismatch.
- Decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - dash=0111111, blank=1111111
  - Nibbles >= 10 cannot occur; decode them as blank.
- Leading-zero blanking (LZ_BLANK=1, not overflow): digit k is blank if it and every more significant digit are 0. Digit 0 is never blanked.
- Reset mid-conversion: the conversion is aborted, the display shows reset state, and the shadow is 0. A nonzero DataIn starts a fresh conversion after rst releases.

Test Plan (SCAN_DIV=4):
- Hold rst low, then release with DataIn=0 -> Anode=8'hFE, Segments=7'b1000000, Busy=0, Overflow=0, no conversion starts; Anode steps FE->FD->FB every 4 cycles.
- DataIn=32'h000004D2 (1234) -> Busy high 33 cycles; then:
  - digits 0..3 show 0011001, 0110000, 0100100, 1111001;
  - digits 4..7 show 1111111.
- DataIn=32'h05F5E0FF (99_999_999) -> Overflow=0, all 8 digits show 0010000.
- DataIn=32'h05F5E100 (100_000_000) -> Overflow=1, all 8 digits show 0111111.
- DataIn=1234, then 5 cycles later DataIn=7 -> 1234 is displayed first; a second Busy pulse follows; the final display is digit0=1111000 with the rest blank.
- rst pulsed low during SHIFT with DataIn=1234 -> outputs return to reset values immediately; after release, the conversion reruns and 1234 is displayed.

Source files
------------

// File: rtl/seg7_scan_display.sv
// Converts a 32-bit binary value to 8 BCD digits (sequential double-dabble)
// and scans them onto an 8-digit common-anode 7-segment display.
module seg7_scan_display #(
    parameter int SCAN_DIV = 50000,
    parameter int LZ_BLANK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] DataIn,
    output logic [7:0]  Anode,
    output logic [6:0]  Segments,
    output logic        Busy,
    output logic        Overflow
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [31:0]      bin_q, bin_d;
    logic [39:0]      bcd_q, bcd_d, bcd_adj;
    logic [4:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic [7:0][3:0]  disp_q, disp_d;

    logic [PW-1:0]    presc_q, presc_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       anode_q, anode_d;
    logic [6:0]       seg_q, seg_d;
    logic [7:0]       blank;
    logic             zero_run;

    function automatic logic [6:0] seg_decode(input logic [3:0] d, input logic blk,
                                              input logic dash);
        logic [6:0] s;
        if (dash)      s = 7'b0111111;
        else if (blk)  s = 7'b1111111;
        else begin
            case (d)
                4'd0:    s = 7'b1000000;
                4'd1:    s = 7'b1111001;
                4'd2:    s = 7'b0100100;
                4'd3:    s = 7'b0110000;
                4'd4:    s = 7'b0011001;
                4'd5:    s = 7'b0010010;
                4'd6:    s = 7'b0000010;
                4'd7:    s = 7'b1111000;
                4'd8:    s = 7'b0000000;
                4'd9:    s = 7'b0010000;
                default: s = 7'b1111111;
            endcase
        end
        return s;
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        ovf_d    = ovf_q;
        disp_d   = disp_q;
        case (state_q)
            IDLE: begin
                if (DataIn != shadow_q) begin
                    shadow_d = DataIn;
                    bin_d    = DataIn;
                    bcd_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj[38:0], bin_q, 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31)
                    state_d = DONE;
            end
            DONE: begin
                // Overflow alone selects the dash pattern; stored digits are cleared.
                if (bcd_q[39:32] != 8'd0) begin
                    ovf_d  = 1'b1;
                    disp_d = '0;
                end else begin
                    ovf_d  = 1'b0;
                    disp_d = bcd_q[31:0];
                end
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            disp_q   <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            disp_q   <= disp_d;
        end
    end

    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int k = 7; k >= 1; k--) begin
            zero_run = zero_run && (disp_q[k] == 4'd0);
            blank[k] = (LZ_BLANK != 0) && !ovf_q && zero_run;
        end
    end

    // Anode and Segments are both computed from the next index so they switch together.
    always_comb begin
        presc_d = (presc_q == PMAX) ? '0 : presc_q + PW'(1);
        idx_d   = (presc_q == PMAX) ? idx_q + 3'd1 : idx_q;
        anode_d = ~(8'b1 << idx_d);
        seg_d   = seg_decode(disp_q[idx_d], blank[idx_d], ovf_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            anode_q <= 8'b11111110;
            seg_q   <= 7'b1000000;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
        end
    end

    assign Anode    = anode_q;
    assign Segments = seg_q;
    assign Busy     = busy_q;
    assign Overflow = ovf_q;

endmodule
